// File: rtl/sseg_num_writer.sv
// Binary-to-BCD writer for the seven-segment array's per-digit write port.
// Ports: start/mag/neg/dp_en/dp_pos in, busy/done/ovf status, wr/sel/val/en/sign/dp + done_tick to the array.
// Optional leading-zero blanking: define SSEG_NUM_WRITER_LZB_EN.
module sseg_num_writer #(
  parameter int SSEG_BITS = 3,
  parameter int SSEG_N    = 4,
  parameter int VAL_BITS  = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VAL_BITS-1:0]  mag,
  input  logic                 neg,
  input  logic                 dp_en,
  input  logic [SSEG_BITS-1:0] dp_pos,
  input  logic                 done_tick,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 wr,
  output logic [SSEG_BITS-1:0] sel,
  output logic [3:0]           val,
  output logic                 en,
  output logic                 sign,
  output logic                 dp
);

  localparam int DW = 4 * SSEG_N;
  localparam int CW = $clog2(VAL_BITS + 1);
  localparam logic [31:0] POS_LIM = 32'(10**SSEG_N - 1);
  localparam logic [31:0] NEG_LIM = 32'(10**(SSEG_N - 1) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_FMT, S_WR, S_WAIT
  } state_t;

  state_t               state;
  logic [VAL_BITS-1:0]  bin;
  logic [DW-1:0]        bcd;
  logic [CW-1:0]        cnt;
  logic [SSEG_BITS-1:0] idx;
  logic                 neg_q;
  logic                 dpen_q;
  logic [SSEG_BITS-1:0] dppos_q;
  logic                 ovf_q;

  logic [SSEG_N-1:0][3:0] fval;
  logic [SSEG_N-1:0]      fen;
  logic [SSEG_N-1:0]      fsign;
  logic [SSEG_N-1:0]      fdp;

  logic [DW-1:0]          bcd_adj;
  logic [DW+VAL_BITS-1:0] sh;
  logic                   ovf_chk;

  logic [SSEG_N-1:0][3:0] f_val;
  logic [SSEG_N-1:0]      f_en;
  logic [SSEG_N-1:0]      f_sign;
  logic [SSEG_N-1:0]      f_dp;

  logic [3:0] r_val;
  logic       r_en;
  logic       r_sign;
  logic       r_dp;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < SSEG_N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    sh = {bcd_adj, bin} << 1;
  end

  // Overflow is a plain magnitude compare; the BCD keeps only SSEG_N digits.
  always_comb begin
    if (neg)
      ovf_chk = 32'(mag) > NEG_LIM;
    else
      ovf_chk = 32'(mag) > POS_LIM;
  end

`ifdef SSEG_NUM_WRITER_LZB_EN
  logic [SSEG_N-1:1] hz;

  // hz[k]: every BCD digit from k upward is zero.
  always_comb begin
    logic z;
    z  = 1'b1;
    hz = '0;
    for (int k = SSEG_N - 1; k >= 1; k--) begin
      z     = z & (bcd[4*k +: 4] == 4'd0);
      hz[k] = z;
    end
  end
`endif

  always_comb begin
    f_val  = '0;
    f_en   = '1;
    f_sign = '0;
    f_dp   = '0;
    for (int k = 0; k < SSEG_N; k++) begin
      f_val[k] = bcd[4*k +: 4];
      f_dp[k]  = dpen_q && (dppos_q == SSEG_BITS'(k));
    end
`ifdef SSEG_NUM_WRITER_LZB_EN
    for (int k = 1; k < SSEG_N; k++) begin
      if (hz[k] && !(dpen_q && (SSEG_BITS'(k) <= dppos_q)))
        f_en[k] = 1'b0;
    end
`endif
    if (neg_q) begin
      f_en[SSEG_N-1]   = 1'b1;
      f_sign[SSEG_N-1] = 1'b1;
      f_val[SSEG_N-1]  = 4'd0;
    end
    if (ovf_q) begin
      f_val  = '0;
      f_en   = '1;
      f_sign = '1;
      f_dp   = '0;
    end
  end

  always_comb begin
    r_val  = 4'd0;
    r_en   = 1'b0;
    r_sign = 1'b0;
    r_dp   = 1'b0;
    for (int k = 0; k < SSEG_N; k++) begin
      if (idx == SSEG_BITS'(k)) begin
        r_val  = fval[k];
        r_en   = fen[k];
        r_sign = fsign[k];
        r_dp   = fdp[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      idx     <= '0;
      neg_q   <= 1'b0;
      dpen_q  <= 1'b0;
      dppos_q <= '0;
      ovf_q   <= 1'b0;
      fval    <= '0;
      fen     <= '0;
      fsign   <= '0;
      fdp     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      wr      <= 1'b0;
      sel     <= '0;
      val     <= '0;
      en      <= 1'b0;
      sign    <= 1'b0;
      dp      <= 1'b0;
    end else begin
      done <= 1'b0;
      wr   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            bin     <= mag;
            bcd     <= '0;
            cnt     <= '0;
            neg_q   <= neg;
            dpen_q  <= dp_en;
            dppos_q <= dp_pos;
            ovf_q   <= ovf_chk;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd <= sh[DW+VAL_BITS-1:VAL_BITS];
          bin <= sh[VAL_BITS-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(VAL_BITS - 1))
            state <= S_FMT;
        end
        S_FMT: begin
          fval  <= f_val;
          fen   <= f_en;
          fsign <= f_sign;
          fdp   <= f_dp;
          ovf   <= ovf_q;
          idx   <= '0;
          state <= S_WR;
        end
        S_WR: begin
          wr    <= 1'b1;
          sel   <= idx;
          val   <= r_val;
          en    <= r_en;
          sign  <= r_sign;
          dp    <= r_dp;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // wr still high here means this is the strobe cycle itself.
          if (done_tick && !wr) begin
            if (idx == SSEG_BITS'(SSEG_N - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_WR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_num_writer.sv
// Self-checking bench for sseg_num_writer: vector table, corner sequences,
// and random requests against an arithmetic reference model.
module tb_sseg_num_writer;

  localparam int N  = 4;
  localparam int VB = 14;
  localparam int SB = 3;
`ifdef SSEG_NUM_WRITER_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef logic [N-1:0][9:0] wexp_t;

  typedef struct {
    int         m;
    int         n;
    int         de;
    int         dpp;
    logic       eovf;
    logic [15:0] vals;
    logic [3:0] en_lzb;
    logic [3:0] sg;
    logic [3:0] dpx;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [VB-1:0] mag;
  logic          neg;
  logic          dp_en;
  logic [SB-1:0] dp_pos;
  logic          done_tick;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          wr;
  logic [SB-1:0] sel;
  logic [3:0]    val;
  logic          en;
  logic          sign;
  logic          dp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tick_mode = 1;
  int tcnt = 0;
  int s_edge = 0;
  logic [9:0] wq[$];
  int wcyc[$];
  vec_t vecs[13];

  sseg_num_writer #(
    .SSEG_BITS(SB),
    .SSEG_N(N),
    .VAL_BITS(VB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mag(mag),
    .neg(neg),
    .dp_en(dp_en),
    .dp_pos(dp_pos),
    .done_tick(done_tick),
    .busy(busy),
    .done(done),
    .ovf(ovf),
    .wr(wr),
    .sel(sel),
    .val(val),
    .en(en),
    .sign(sign),
    .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr) begin
      wq.push_back({sel, val, en, sign, dp});
      wcyc.push_back(cyc);
    end
  end

  // 0: pulse every 8 clocks, 1: idle, 2: pulse only alongside wr
  initial begin
    done_tick = 1'b0;
    forever begin
      @(negedge clk);
      case (tick_mode)
        0: begin
          tcnt++;
          done_tick = (tcnt % 8 == 0);
        end
        2: done_tick = wr;
        default: done_tick = 1'b0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic bitk(input logic [15:0] x, input int k);
    logic [15:0] t;
    t = x >> k;
    return t[0];
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] x, input int k);
    logic [15:0] t;
    t = x >> (4 * k);
    return t[3:0];
  endfunction

  function automatic wexp_t model(input int m, input int n, input int de,
                                  input int dpp, output logic eovf);
    wexp_t r;
    int pw;
    logic [3:0] d;
    logic e, s, p;
    eovf = m > ((n != 0) ? 999 : 9999);
    pw = 1;
    for (int k = 0; k < N; k++) begin
      d = 4'((m / pw) % 10);
      e = 1'b1;
      s = 1'b0;
      p = (de != 0) && (dpp == k);
      if (LZB && k > 0 && m < pw && !(de != 0 && k <= dpp))
        e = 1'b0;
      if (n != 0 && k == N - 1) begin
        d = 4'd0;
        e = 1'b1;
        s = 1'b1;
      end
      if (eovf) begin
        d = 4'd0;
        e = 1'b1;
        s = 1'b1;
        p = 1'b0;
      end
      r[k] = {3'(k), d, e, s, p};
      pw = pw * 10;
    end
    return r;
  endfunction

  task automatic start_req(input int m, input int n, input int de,
                           input int dpp, input bit clr);
    @(negedge clk);
    if (clr) begin
      wq.delete();
      wcyc.delete();
    end
    mag    = VB'(m);
    neg    = (n != 0);
    dp_en  = (de != 0);
    dp_pos = SB'(dpp);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s_edge = cyc;
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s done timeout", nm);
    end else begin
      chk({nm, "_busy_at_done"}, 32'(busy), 0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, 32'(done), 0);
    end
  endtask

  task automatic check_writes(input string nm, input wexp_t e,
                              input logic eovf, input int st);
    logic [9:0] g;
    chk({nm, "_nwr"}, 32'(wq.size()), 4);
    if (wcyc.size() > 0)
      chk({nm, "_lat"}, 32'(wcyc[0] - st), 16);
    for (int k = 0; k < N; k++) begin
      g = (k < wq.size()) ? wq[k] : 10'h3ff;
      chk($sformatf("%s_wr%0d", nm, k), 32'(g), 32'(e[k]));
    end
    chk({nm, "_ovf"}, 32'(ovf), 32'(eovf));
  endtask

  initial begin
    wexp_t e;
    logic eo;
    int s5;
    int m, n, de, dpp;

    reset  = 1'b0;
    start  = 1'b0;
    mag    = '0;
    neg    = 1'b0;
    dp_en  = 1'b0;
    dp_pos = '0;

    vecs[0]  = '{1234, 0, 0, 0, 1'b0, 16'h1234, 4'hF, 4'h0, 4'h0};
    vecs[1]  = '{7, 1, 0, 0, 1'b0, 16'h0007, 4'b1001, 4'b1000, 4'h0};
    vecs[2]  = '{10000, 0, 0, 0, 1'b1, 16'h0000, 4'hF, 4'hF, 4'h0};
    vecs[3]  = '{999, 1, 0, 0, 1'b0, 16'h0999, 4'hF, 4'b1000, 4'h0};
    vecs[4]  = '{1000, 1, 0, 0, 1'b1, 16'h0000, 4'hF, 4'hF, 4'h0};
    vecs[5]  = '{5, 0, 1, 2, 1'b0, 16'h0005, 4'b0111, 4'h0, 4'b0100};
    vecs[6]  = '{9999, 0, 0, 0, 1'b0, 16'h9999, 4'hF, 4'h0, 4'h0};
    vecs[7]  = '{0, 0, 0, 0, 1'b0, 16'h0000, 4'b0001, 4'h0, 4'h0};
    vecs[8]  = '{0, 1, 1, 0, 1'b0, 16'h0000, 4'b1001, 4'b1000, 4'b0001};
    vecs[9]  = '{16383, 0, 0, 0, 1'b1, 16'h0000, 4'hF, 4'hF, 4'h0};
    vecs[10] = '{1000, 0, 1, 3, 1'b0, 16'h1000, 4'hF, 4'h0, 4'b1000};
    vecs[11] = '{50, 0, 0, 0, 1'b0, 16'h0050, 4'b0011, 4'h0, 4'h0};
    vecs[12] = '{10000, 0, 1, 1, 1'b1, 16'h0000, 4'hF, 4'hF, 4'h0};

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({busy, done, ovf, wr, sel, val, en, sign, dp}), 0);
    reset = 1'b1;
    tick_mode = 0;

    for (int v = 0; v < 13; v++) begin
      for (int k = 0; k < N; k++)
        e[k] = {3'(k), nib(vecs[v].vals, k),
                LZB ? bitk(16'(vecs[v].en_lzb), k) : 1'b1,
                bitk(16'(vecs[v].sg), k), bitk(16'(vecs[v].dpx), k)};
      start_req(vecs[v].m, vecs[v].n, vecs[v].de, vecs[v].dpp, 1'b1);
      chk($sformatf("vec%0d_busy", v), 32'(busy), 1);
      wait_done($sformatf("vec%0d", v));
      check_writes($sformatf("vec%0d", v), e, vecs[v].eovf, s_edge);
    end

    // done_tick only during strobe cycles, plus a start while busy
    tick_mode = 2;
    start_req(4321, 0, 0, 0, 1'b1);
    s5 = s_edge;
    repeat (20) @(negedge clk);
    start_req(1, 1, 1, 0, 1'b0);
    repeat (20) @(negedge clk);
    chk("t5_stuck_nwr", 32'(wq.size()), 1);
    chk("t5_busy", 32'(busy), 1);
    tick_mode = 0;
    wait_done("t5");
    e = model(4321, 0, 0, 0, eo);
    check_writes("t5", e, eo, s5);

    // reset while waiting after digit 1
    start_req(10000, 0, 0, 0, 1'b1);
    for (int i = 0; i < 300 && wq.size() < 2; i++) @(negedge clk);
    chk("t6_reach", 32'(wq.size()), 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_ctl", 32'({wr, busy, done, ovf}), 0);
    chk("t6_rst_data", 32'({sel, val, en, sign, dp}), 0);
    repeat (30) @(negedge clk);
    chk("t6_no_wr", 32'(wq.size()), 2);
    reset = 1'b1;
    start_req(305, 0, 1, 1, 1'b1);
    wait_done("t6_after");
    e = model(305, 0, 1, 1, eo);
    check_writes("t6_after", e, eo, s_edge);

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 3))
        0: m = $urandom_range(0, 99);
        1: m = $urandom_range(0, 9999);
        2: m = $urandom_range(990, 1010) + (($urandom_range(0, 1) != 0) ? 9000 : 0);
        default: m = $urandom_range(0, 16383);
      endcase
      n   = $urandom_range(0, 1);
      de  = $urandom_range(0, 1);
      dpp = $urandom_range(0, 7);
      e = model(m, n, de, dpp, eo);
      start_req(m, n, de, dpp, 1'b1);
      wait_done($sformatf("rnd%0d", r));
      check_writes($sformatf("rnd%0d_m%0d_n%0d", r, m, n), e, eo, s_edge);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
